// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the sequence
// controller (port 0) and the loader/debug port (port 1).
module mem_arbiter #(
  parameter int AWIDTH      = 5,
  parameter int DWIDTH      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_wr,
  input  logic [AWIDTH-1:0] req0_addr,
  input  logic [DWIDTH-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_done,
  output logic [DWIDTH-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_wr,
  input  logic [AWIDTH-1:0] req1_addr,
  input  logic [DWIDTH-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_done,
  output logic [DWIDTH-1:0] req1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_e            state_q;
  logic              last_grant_q;
  logic              port_q;
  logic              wr_q;
  logic [3:0]        wait_cnt_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [DWIDTH-1:0] rdata0_q;
  logic [DWIDTH-1:0] rdata1_q;
  logic              done0_q;
  logic              done1_q;
  logic              gnt0_d;
  logic              gnt1_d;

  // Grants only in IDLE; on contention the port that did not win last time goes.
  always_comb begin
    gnt0_d = 1'b0;
    gnt1_d = 1'b0;
    if (!rst && state_q == IDLE) begin
      gnt0_d = req0_valid && (!req1_valid || last_grant_q);
      gnt1_d = req1_valid && (!req0_valid || !last_grant_q);
    end
  end

  assign req0_ready = gnt0_d;
  assign req1_ready = gnt1_d;
  assign req0_done  = done0_q;
  assign req1_done  = done1_q;
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;

  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = mem_en & wr_q;
  assign mem_addr  = mem_en ? addr_q  : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      wr_q         <= 1'b0;
      wait_cnt_q   <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt0_d || gnt1_d) begin
            state_q      <= ACCESS;
            port_q       <= gnt1_d;
            last_grant_q <= gnt1_d;
            wait_cnt_q   <= '0;
            wr_q         <= gnt1_d ? req1_wr    : req0_wr;
            addr_q       <= gnt1_d ? req1_addr  : req0_addr;
            wdata_q      <= gnt1_d ? req1_wdata : req0_wdata;
          end
        end
        ACCESS: begin
          wait_cnt_q <= wait_cnt_q + 4'd1;
          if (wait_cnt_q == WAIT_LAST) begin
            state_q <= DONE;
            done0_q <= !port_q;
            done1_q <= port_q;
            // Read data is only guaranteed valid in the final access cycle.
            if (!wr_q) begin
              if (port_q) rdata1_q <= mem_rdata;
              else        rdata0_q <= mem_rdata;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
